// File: rtl/gpio_bank.sv
// gpio_bank: multi-bank 8-bit GPIO peripheral on the Picoblaze port bus.
//
// Each bank owns eight consecutive port addresses starting at
// GPIO_BASE_ADDRESS + 8*b:
//   +0 OEN (R/W)        +1 DATA (R: synced pins, W: output register)
//   +2 SET (W, reads 0) +3 CLR (W, reads 0)
//   +4 IRQ_MASK (R/W)   +5 IRQ_STATUS (R, W1C)
//   +6 EDGE_SEL (R/W)   +7 EDGE_BOTH (R/W)
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   port_id, data_in    Picoblaze address / write data
//   data_out            registered read data (decoded every cycle)
//   read_strobe         unused; reads have no side effects
//   write_strobe        write qualifier
//   gpio_oen            per-pin output enable, bank b in [8b+7:8b]
//   gpio_data_out       per-pin output value
//   gpio_data_in        raw asynchronous pin inputs
//   interrupt           registered level interrupt, OR of all banks

module gpio_bank #(
  parameter logic [7:0] GPIO_BASE_ADDRESS = 8'h00,
  parameter int         NUM_BANKS         = 1,
  parameter int         SYNC_STAGES       = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             port_id,
  input  logic [7:0]             data_in,
  output logic [7:0]             data_out,
  input  logic                   read_strobe,
  input  logic                   write_strobe,
  output logic [8*NUM_BANKS-1:0] gpio_oen,
  output logic [8*NUM_BANKS-1:0] gpio_data_out,
  input  logic [8*NUM_BANKS-1:0] gpio_data_in,
  output logic                   interrupt
);

  // ---------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------
  if (NUM_BANKS < 1 || NUM_BANKS > 4) begin : g_bad_num_banks
    $error("gpio_bank: NUM_BANKS must be 1..4");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync_stages
    $error("gpio_bank: SYNC_STAGES must be 2..3");
  end
  if (GPIO_BASE_ADDRESS[2:0] != 3'b000) begin : g_bad_base_align
    $error("gpio_bank: GPIO_BASE_ADDRESS must be a multiple of 8");
  end
  if (int'(GPIO_BASE_ADDRESS) + 8 * NUM_BANKS > 256) begin : g_bad_base_range
    $error("gpio_bank: address window exceeds the 8-bit port space");
  end

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  // 9-bit subtraction: bit 8 set means port_id is below the base.
  logic [8:0] rel;
  logic       in_range;
  logic [2:0] offset;

  assign rel      = {1'b0, port_id} - {1'b0, GPIO_BASE_ADDRESS};
  assign in_range = !rel[8] && (rel < 9'(8 * NUM_BANKS));
  // Base is 8-aligned, so the register offset is just the low address bits.
  assign offset   = port_id[2:0];

  // Tie off inputs/bits that carry no function.
  logic unused_bits;
  assign unused_bits = ^{read_strobe, rel[2:0]};

  // ---------------------------------------------------------------------
  // Bank array
  // ---------------------------------------------------------------------
  logic [NUM_BANKS-1:0][7:0] oen_b;
  logic [NUM_BANKS-1:0][7:0] dout_b;
  logic [NUM_BANKS-1:0][7:0] rd_b;
  logic [NUM_BANKS-1:0]      pend_b;
  logic [NUM_BANKS-1:0]      hit_b;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign hit_b[b] = in_range && (rel[7:3] == 5'(b));

    gpio_bank_slice #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_slice (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (write_strobe & hit_b[b]),
      .sel      (hit_b[b]),
      .offset   (offset),
      .wr_data  (data_in),
      .pin_in   (gpio_data_in[8*b +: 8]),
      .oen      (oen_b[b]),
      .dout     (dout_b[b]),
      .rd_data  (rd_b[b]),
      .irq_pend (pend_b[b])
    );
  end

  assign gpio_oen      = oen_b;
  assign gpio_data_out = dout_b;

  // Unselected slices return zero, so the read mux is a plain OR.
  logic [7:0] rd_mux;
  always_comb begin
    rd_mux = 8'h00;
    for (int b = 0; b < NUM_BANKS; b++) rd_mux = rd_mux | rd_b[b];
  end

  // Read data and interrupt are both registered; unmapped addresses read 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out  <= 8'h00;
      interrupt <= 1'b0;
    end else begin
      data_out  <= rd_mux;
      interrupt <= |pend_b;
    end
  end

endmodule

// gpio_bank_slice: one 8-pin bank.
//
// Ports:
//   clk, reset    shared clock / synchronous reset
//   wr_en         write strobe already qualified by this bank's address hit
//   sel           this bank is addressed (gates read data)
//   offset        register offset within the bank
//   wr_data       write data
//   pin_in        raw asynchronous pins
//   oen, dout     output enable and output value registers
//   rd_data       combinational read data, zero when not selected
//   irq_pend      any unmasked status bit set
module gpio_bank_slice #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic       sel,
  input  logic [2:0] offset,
  input  logic [7:0] wr_data,
  input  logic [7:0] pin_in,
  output logic [7:0] oen,
  output logic [7:0] dout,
  output logic [7:0] rd_data,
  output logic       irq_pend
);

  localparam logic [2:0] OFF_OEN  = 3'd0;
  localparam logic [2:0] OFF_DATA = 3'd1;
  localparam logic [2:0] OFF_SET  = 3'd2;
  localparam logic [2:0] OFF_CLR  = 3'd3;
  localparam logic [2:0] OFF_MASK = 3'd4;
  localparam logic [2:0] OFF_STAT = 3'd5;
  localparam logic [2:0] OFF_ESEL = 3'd6;
  localparam logic [2:0] OFF_BOTH = 3'd7;

  // ---------------------------------------------------------------------
  // Input synchroniser + previous-value flop. Deliberately not reset:
  // they keep sampling through reset so pin levels are settled by the
  // time reset releases, and no spurious edge is seen afterwards.
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][7:0] sync_q;
  logic [7:0]                  prev_q;
  logic [7:0]                  sync_v;

  always_ff @(posedge clk) begin
    sync_q <= {sync_q[SYNC_STAGES-2:0], pin_in};
    prev_q <= sync_q[SYNC_STAGES-1];
  end

  assign sync_v = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  logic [7:0] oen_q, dout_q, mask_q, stat_q, esel_q, both_q;

  logic [7:0] rise, fall, evt, w1c;

  assign rise = sync_v & ~prev_q;
  assign fall = ~sync_v & prev_q;
  // EDGE_BOTH takes priority over EDGE_SEL, bit by bit.
  assign evt  = (both_q & (rise | fall)) |
                (~both_q & ((esel_q & fall) | (~esel_q & rise)));
  assign w1c  = (wr_en && offset == OFF_STAT) ? wr_data : 8'h00;

  always_ff @(posedge clk) begin
    if (reset) begin
      oen_q  <= 8'h00;
      dout_q <= 8'h00;
      mask_q <= 8'hFF;
      stat_q <= 8'h00;
      esel_q <= 8'h00;
      both_q <= 8'h00;
    end else begin
      if (wr_en) begin
        case (offset)
          OFF_OEN:  oen_q  <= wr_data;
          OFF_DATA: dout_q <= wr_data;
          OFF_SET:  dout_q <= dout_q | wr_data;
          OFF_CLR:  dout_q <= dout_q & ~wr_data;
          OFF_MASK: mask_q <= wr_data;
          OFF_ESEL: esel_q <= wr_data;
          OFF_BOTH: both_q <= wr_data;
          default:  ;
        endcase
      end
      // Event is ORed in after the clear so a colliding event wins.
      stat_q <= (stat_q & ~w1c) | evt;
    end
  end

  // ---------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------
  logic [7:0] rd_val;
  always_comb begin
    rd_val = 8'h00;
    case (offset)
      OFF_OEN:  rd_val = oen_q;
      OFF_DATA: rd_val = sync_v;
      OFF_MASK: rd_val = mask_q;
      OFF_STAT: rd_val = stat_q;
      OFF_ESEL: rd_val = esel_q;
      OFF_BOTH: rd_val = both_q;
      default:  rd_val = 8'h00;
    endcase
  end

  assign rd_data  = sel ? rd_val : 8'h00;
  assign oen      = oen_q;
  assign dout     = dout_q;
  assign irq_pend = |(stat_q & ~mask_q);

endmodule

// File: tb/tb_gpio_bank.sv
module tb_gpio_bank;

  localparam logic [7:0] BASE = 8'h10;
  localparam int         NB   = 2;
  localparam int         SS   = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        port_id, data_in, data_out;
  logic              read_strobe, write_strobe;
  logic [8*NB-1:0]   gpio_oen, gpio_data_out, gpio_data_in;
  logic              interrupt;

  always #5 clk = ~clk;

  gpio_bank #(
    .GPIO_BASE_ADDRESS (BASE),
    .NUM_BANKS         (NB),
    .SYNC_STAGES       (SS)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .port_id       (port_id),
    .data_in       (data_in),
    .data_out      (data_out),
    .read_strobe   (read_strobe),
    .write_strobe  (write_strobe),
    .gpio_oen      (gpio_oen),
    .gpio_data_out (gpio_data_out),
    .gpio_data_in  (gpio_data_in),
    .interrupt     (interrupt)
  );

  typedef struct {
    int          kind;
    logic [15:0] exp;
    string       name;
  } sb_t;

  sb_t  sbq[$];
  logic chk_vld = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  sb_t         mon_e;
  logic [15:0] mon_got;

  always @(negedge clk) begin
    if (chk_vld) begin
      while (sbq.size() > 0) begin
        mon_e = sbq.pop_front();
        case (mon_e.kind)
          0:       mon_got = {8'h00, data_out};
          1:       mon_got = {15'h0, interrupt};
          2:       mon_got = gpio_data_out;
          default: mon_got = gpio_oen;
        endcase
        n_tests++;
        if (mon_got !== mon_e.exp) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", mon_e.name, mon_got, mon_e.exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input int kind, input logic [15:0] exp, input string name);
    sb_t e;
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    sbq.push_back(e);
  endtask

  task automatic sample();
    chk_vld = 1'b1;
    @(negedge clk);
    #1;
    chk_vld = 1'b0;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    port_id      = addr;
    data_in      = data;
    write_strobe = 1'b1;
    step();
    write_strobe = 1'b0;
  endtask

  task automatic rd(input logic [7:0] addr, input logic [7:0] exp, input string name);
    port_id = addr;
    step();
    expect_v(0, {8'h00, exp}, name);
    sample();
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    reset        = 1'b1;
    port_id      = 8'h00;
    data_in      = 8'h00;
    read_strobe  = 1'b0;
    write_strobe = 1'b0;
    gpio_data_in = '0;
    wait_cycles(4);

    expect_v(1, 16'h0000, "rst_interrupt");
    expect_v(2, 16'h0000, "rst_gpio_data_out");
    expect_v(3, 16'h0000, "rst_gpio_oen");
    sample();
    reset = 1'b0;
    step();

    for (int b = 0; b < NB; b++)
      for (int o = 0; o < 8; o++)
        rd(BASE + 8'(8 * b + o), (o == 4) ? 8'hFF : 8'h00,
           $sformatf("rst_b%0d_o%0d", b, o));

    wr(BASE + 8'h08, 8'h3C);
    expect_v(3, 16'h3C00, "oen_b1");
    sample();
    wr(BASE + 8'h09, 8'hA5);
    expect_v(2, 16'hA500, "data_write_a5");
    sample();
    wr(BASE + 8'h0A, 8'h0A);
    expect_v(2, 16'hAF00, "set_0a");
    sample();
    wr(BASE + 8'h0B, 8'h81);
    expect_v(2, 16'h2E00, "clr_81");
    sample();
    rd(BASE + 8'h0A, 8'h00, "set_reads_zero");
    rd(BASE + 8'h08, 8'h3C, "oen_b1_readback");

    wr(BASE + 8'h04, 8'h00);
    wr(BASE + 8'h06, 8'h02);
    wr(BASE + 8'h07, 8'h04);
    port_id = BASE + 8'h05;
    step();
    gpio_data_in[7:0] = 8'h07;
    step();
    step();
    step();
    expect_v(0, 16'h0000, "rise_status_before");
    expect_v(1, 16'h0000, "rise_irq_k2");
    sample();
    step();
    expect_v(0, 16'h0005, "rise_status");
    expect_v(1, 16'h0001, "rise_irq_k3");
    sample();
    wr(BASE + 8'h05, 8'hFF);
    expect_v(1, 16'h0001, "w1c_irq_same_edge");
    sample();
    step();
    expect_v(1, 16'h0000, "w1c_irq_next_edge");
    sample();
    rd(BASE + 8'h05, 8'h00, "w1c_status");
    gpio_data_in[7:0] = 8'h00;
    wait_cycles(4);
    rd(BASE + 8'h05, 8'h06, "fall_status");
    expect_v(1, 16'h0001, "fall_irq");
    sample();
    wr(BASE + 8'h05, 8'hFF);

    wr(BASE + 8'h04, 8'hFE);
    wr(BASE + 8'h06, 8'h00);
    wr(BASE + 8'h07, 8'h00);
    gpio_data_in[7:0] = 8'h08;
    wait_cycles(4);
    rd(BASE + 8'h05, 8'h08, "mask_status");
    expect_v(1, 16'h0000, "mask_irq_low");
    sample();
    wr(BASE + 8'h04, 8'hF7);
    expect_v(1, 16'h0000, "unmask_irq_same_edge");
    sample();
    step();
    expect_v(1, 16'h0001, "unmask_irq_next_edge");
    sample();

    wr(BASE + 8'h05, 8'hFF);
    wr(BASE + 8'h04, 8'h00);
    gpio_data_in[7:0] = 8'h0B;
    wait_cycles(4);
    rd(BASE + 8'h05, 8'h03, "coll_pre_status");
    gpio_data_in[7:0] = 8'h0A;
    wait_cycles(4);
    gpio_data_in[7:0] = 8'h0B;
    step();
    step();
    wr(BASE + 8'h05, 8'h03);
    expect_v(1, 16'h0001, "coll_irq_same_edge");
    sample();
    step();
    expect_v(1, 16'h0001, "coll_irq_next_edge");
    sample();
    rd(BASE + 8'h05, 8'h01, "coll_status");

    wr(BASE + 8'(8 * NB), 8'h55);
    rd(BASE + 8'(8 * NB), 8'h00, "unmapped_read_hi");
    rd(BASE - 8'h08, 8'h00, "unmapped_read_lo");
    rd(BASE + 8'h00, 8'h00, "unmapped_no_oen_b0");
    rd(BASE + 8'h04, 8'h00, "unmapped_no_mask_b0");
    expect_v(3, 16'h3C00, "unmapped_oen_pins");
    expect_v(2, 16'h2E00, "unmapped_dout_pins");
    sample();

    wr(BASE + 8'h05, 8'hFF);
    wr(BASE + 8'h07, 8'hFF);
    gpio_data_in[7:0] = 8'hF4;
    wait_cycles(4);
    rd(BASE + 8'h01, 8'hF4, "data_sync_read");
    rd(BASE + 8'h05, 8'hFF, "all_edges_status");
    expect_v(1, 16'h0001, "all_edges_irq");
    sample();
    reset = 1'b1;
    step();
    expect_v(1, 16'h0000, "reset_irq_drop");
    expect_v(3, 16'h0000, "reset_oen");
    expect_v(2, 16'h0000, "reset_dout");
    sample();
    wait_cycles(3);
    reset = 1'b0;
    rd(BASE + 8'h05, 8'h00, "reset_status");
    rd(BASE + 8'h04, 8'hFF, "reset_mask_b0");
    rd(BASE + 8'h0C, 8'hFF, "reset_mask_b1");
    rd(BASE + 8'h07, 8'h00, "reset_both_b0");
    expect_v(1, 16'h0000, "reset_irq_after");
    sample();

    n_tests++;
    if (interrupt !== 1'b0) begin
      n_fail++;
      $display("FAIL final_interrupt: got %b expected 0", interrupt);
    end
    n_tests++;
    if (gpio_oen !== '0) begin
      n_fail++;
      $display("FAIL final_gpio_oen: got %h expected 0", gpio_oen);
    end
    n_tests++;
    if (gpio_data_out !== '0) begin
      n_fail++;
      $display("FAIL final_gpio_data_out: got %h expected 0", gpio_data_out);
    end
    n_tests++;
    if (data_out !== 8'h00) begin
      n_fail++;
      $display("FAIL final_data_out: got %h expected 00", data_out);
    end

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    if (n_fail != 0) $display("FAIL: %0d checks failed", n_fail);
    else             $display("PASS");
    $finish;
  end

endmodule
